// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external SRAM port and the UART register port between the
// instruction-fetch stage (read only) and the MEM stage (read/write).
// An access is granted from IDLE and runs through S_SRAM (fixed wait count)
// or S_UART (handshake with timeout). Every access then passes through
// S_DONE, which produces a one-cycle ack with data and error.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   if_ce_i/if_addr_i          IF read request (held until if_ack_o)
//   if_data_o/if_ack_o         IF read data and one-cycle completion pulse
//   mem_ce_i/mem_we_i/...      MEM request, write flag, address, byte enables, write data
//   mem_data_o/mem_ack_o       MEM read data and one-cycle completion pulse
//   bus_err_o                  pulses with ack on unmapped address or UART timeout
//   stall_req_o                pipeline stall while any request is not yet acked
//   sram_*                     SRAM controller side (word address = addr[21:2])
//   uart_*                     UART register side (reg 0 = data, 1 = status)
module mem_bus_arbiter #(
    parameter int SRAM_WAIT    = 2,
    parameter int UART_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        bus_err_o,
    output logic        stall_req_o,
    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [19:0] sram_addr_o,
    output logic [3:0]  sram_be_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    output logic        uart_ce_o,
    output logic        uart_we_o,
    output logic        uart_reg_o,
    output logic [7:0]  uart_wdata_o,
    input  logic [7:0]  uart_rdata_i,
    input  logic        uart_ready_i
);

    localparam logic [7:0] WAIT_CNT    = 8'(SRAM_WAIT);
    localparam logic [7:0] TIMEOUT_CNT = 8'(UART_TIMEOUT);

    typedef enum logic [1:0] {IDLE, S_SRAM, S_UART, S_DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        owner_mem;
    logic        last_mem;
    logic        err;
    logic [31:0] data_q;

    logic        mem_req, if_req, grant_mem, grant_if;
    logic [31:0] g_addr, g_wdata;
    logic        g_we;
    logic [3:0]  g_sel;
    logic        hit_sram, hit_uart;
    logic [7:0]  lane;

    // A requester whose ack is showing this cycle is still holding ce until
    // the pipeline samples the ack, so it is masked here to avoid a regrant.
    // MEM normally wins; IF takes the bus when MEM went last, so the two
    // alternate under sustained contention.
    always_comb begin
        mem_req   = mem_ce_i & ~mem_ack_o;
        if_req    = if_ce_i & ~if_ack_o;
        grant_mem = mem_req & ~(last_mem & if_req);
        grant_if  = if_req & ~grant_mem;
        g_addr    = grant_mem ? mem_addr_i : if_addr_i;
        g_we      = grant_mem & mem_we_i;
        g_sel     = grant_mem ? mem_sel_i : 4'b1111;
        g_wdata   = grant_mem ? mem_data_i : 32'h0;
        hit_sram  = (g_addr[31:23] == 9'h100);
        // IF never reaches the UART; its UART addresses fall through as unmapped.
        hit_uart  = grant_mem & ((g_addr == 32'hBFD0_03F8) | (g_addr == 32'hBFD0_03FC));
        // The UART is byte-wide: forward the lane of the lowest enabled byte.
        casez (g_sel)
            4'b???1: lane = g_wdata[7:0];
            4'b??10: lane = g_wdata[15:8];
            4'b?100: lane = g_wdata[23:16];
            4'b1000: lane = g_wdata[31:24];
            default: lane = g_wdata[7:0];
        endcase
    end

    // Stall follows the raw requests; it is forced low while in reset so that
    // every output reads zero then.
    assign stall_req_o = ~rst & ((mem_ce_i & ~mem_ack_o) | (if_ce_i & ~if_ack_o));

    // Access sequencer. Peripheral outputs are loaded on entry to their state
    // and cleared on exit, so they are registered and zero elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            owner_mem    <= 1'b0;
            last_mem     <= 1'b0;
            err          <= 1'b0;
            data_q       <= 32'h0;
            if_data_o    <= 32'h0;
            if_ack_o     <= 1'b0;
            mem_data_o   <= 32'h0;
            mem_ack_o    <= 1'b0;
            bus_err_o    <= 1'b0;
            sram_ce_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= 20'h0;
            sram_be_o    <= 4'h0;
            sram_wdata_o <= 32'h0;
            uart_ce_o    <= 1'b0;
            uart_we_o    <= 1'b0;
            uart_reg_o   <= 1'b0;
            uart_wdata_o <= 8'h0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_mem | grant_if) begin
                        owner_mem <= grant_mem;
                        if (hit_sram) begin
                            state        <= S_SRAM;
                            cnt          <= WAIT_CNT;
                            err          <= 1'b0;
                            sram_ce_o    <= 1'b1;
                            sram_we_o    <= g_we;
                            sram_addr_o  <= g_addr[21:2];
                            sram_be_o    <= g_sel;
                            sram_wdata_o <= g_we ? g_wdata : 32'h0;
                        end else if (hit_uart) begin
                            state        <= S_UART;
                            cnt          <= 8'd0;
                            err          <= 1'b0;
                            uart_ce_o    <= 1'b1;
                            uart_we_o    <= g_we;
                            uart_reg_o   <= g_addr[2];
                            uart_wdata_o <= lane;
                        end else begin
                            state  <= S_DONE;
                            err    <= 1'b1;
                            data_q <= 32'h0;
                        end
                    end
                end
                S_SRAM: begin
                    // Read data is taken in the last wait cycle.
                    if (cnt == 8'd1) begin
                        data_q       <= sram_we_o ? 32'h0 : sram_rdata_i;
                        state        <= S_DONE;
                        sram_ce_o    <= 1'b0;
                        sram_we_o    <= 1'b0;
                        sram_addr_o  <= 20'h0;
                        sram_be_o    <= 4'h0;
                        sram_wdata_o <= 32'h0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_UART: begin
                    if (uart_ready_i || (cnt + 8'd1 == TIMEOUT_CNT)) begin
                        if (uart_ready_i) begin
                            data_q <= uart_we_o ? 32'h0 : {24'h0, uart_rdata_i};
                        end else begin
                            err    <= 1'b1;
                            data_q <= 32'h0;
                        end
                        state        <= S_DONE;
                        uart_ce_o    <= 1'b0;
                        uart_we_o    <= 1'b0;
                        uart_reg_o   <= 1'b0;
                        uart_wdata_o <= 8'h0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (owner_mem) begin
                        mem_ack_o  <= 1'b1;
                        mem_data_o <= data_q;
                    end else begin
                        if_ack_o  <= 1'b1;
                        if_data_o <= data_q;
                    end
                    bus_err_o <= err;
                    last_mem  <= owner_mem;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter. A timeline model predicts when each granted
// access shows on the SRAM/UART pins and when its ack appears. It is checked
// against the DUT every cycle, and directed scenarios pin literal results.
module tb_mem_bus_arbiter;

    localparam int W = 2;
    localparam int T = 4;
    localparam int K_SRAM = 0;
    localparam int K_UART = 1;
    localparam int K_NONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [3:0]  mem_sel_i = 4'h0;
    logic [31:0] mem_data_i = 32'h0;
    logic [31:0] mem_data_o;
    logic        mem_ack_o;
    logic        bus_err_o;
    logic        stall_req_o;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [19:0] sram_addr_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic        uart_ce_o;
    logic        uart_we_o;
    logic        uart_reg_o;
    logic [7:0]  uart_wdata_o;
    logic [7:0]  uart_rdata_i = 8'h5A;
    logic        uart_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_bus_arbiter #(.SRAM_WAIT(W), .UART_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_ack_o(mem_ack_o),
        .bus_err_o(bus_err_o), .stall_req_o(stall_req_o),
        .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .uart_ce_o(uart_ce_o), .uart_we_o(uart_we_o), .uart_reg_o(uart_reg_o),
        .uart_wdata_o(uart_wdata_o), .uart_rdata_i(uart_rdata_i), .uart_ready_i(uart_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    function automatic logic [7:0] low_lane(input logic [3:0] sel, input logic [31:0] d);
        logic [7:0] r;
        r = d[7:0];
        for (int i = 3; i >= 0; i--) if (sel[i]) r = d[8*i +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // SRAM stub: 64 words behind the low address bits, byte-enabled writes.
    logic [31:0] sram_mem [0:63];
    assign sram_rdata_i = sram_mem[sram_addr_o[5:0]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= pat(i);
        end else if (sram_ce_o && sram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (sram_be_o[b]) sram_mem[sram_addr_o[5:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
    end

    // Reference model: one transaction record with its grant cycle and ack cycle.
    logic [31:0] model_mem [0:63];
    bit          t_act = 1'b0, t_mem, t_we, t_err, last_mem = 1'b0;
    int          t_kind, t_g, t_ack;
    logic [31:0] t_addr, t_wdata, t_data;
    logic [3:0]  t_sel;
    logic [31:0] exp_md = 32'h0, exp_id = 32'h0;
    bit          e_mack, e_iack, e_err, s_on, u_on, e_stall, m_req, i_req;

    initial begin
        forever begin
            @(negedge clk);
            if (preload) for (int i = 0; i < 64; i++) model_mem[i] = pat(i);
            if (rst) begin
                t_act = 1'b0; last_mem = 1'b0; exp_md = 32'h0; exp_id = 32'h0;
            end
            e_mack  = !rst && t_act && t_mem && (cyc == t_ack);
            e_iack  = !rst && t_act && !t_mem && (cyc == t_ack);
            e_err   = (e_mack || e_iack) && t_err;
            if (e_mack) exp_md = t_data;
            if (e_iack) exp_id = t_data;
            s_on    = !rst && t_act && t_kind == K_SRAM && cyc >= t_g && cyc < t_g + W;
            u_on    = !rst && t_act && t_kind == K_UART && cyc >= t_g && (t_ack < 0 || cyc <= t_ack - 2);
            e_stall = !rst && ((mem_ce_i && !e_mack) || (if_ce_i && !e_iack));

            checkOutput("mem_ack", 32'(mem_ack_o), 32'(e_mack));
            checkOutput("if_ack", 32'(if_ack_o), 32'(e_iack));
            checkOutput("bus_err", 32'(bus_err_o), 32'(e_err));
            checkOutput("mem_data", mem_data_o, exp_md);
            checkOutput("if_data", if_data_o, exp_id);
            checkOutput("stall", 32'(stall_req_o), 32'(e_stall));
            checkOutput("sram_ce", 32'(sram_ce_o), 32'(s_on));
            checkOutput("sram_we", 32'(sram_we_o), s_on ? 32'(t_we) : 32'h0);
            checkOutput("sram_addr", 32'(sram_addr_o), s_on ? 32'(t_addr[21:2]) : 32'h0);
            checkOutput("sram_be", 32'(sram_be_o), s_on ? 32'(t_sel) : 32'h0);
            checkOutput("sram_wdata", sram_wdata_o, (s_on && t_we) ? t_wdata : 32'h0);
            checkOutput("uart_ce", 32'(uart_ce_o), 32'(u_on));
            checkOutput("uart_we", 32'(uart_we_o), u_on ? 32'(t_we) : 32'h0);
            checkOutput("uart_reg", 32'(uart_reg_o), u_on ? 32'(t_addr[2]) : 32'h0);
            checkOutput("uart_wdata", 32'(uart_wdata_o), u_on ? 32'(low_lane(t_sel, t_wdata)) : 32'h0);

            if (!rst) begin
                if (t_act && t_kind == K_UART && t_ack < 0 && cyc >= t_g) begin
                    if (uart_ready_i) begin
                        t_ack = cyc + 2; t_err = 1'b0;
                        t_data = t_we ? 32'h0 : {24'h0, uart_rdata_i};
                    end else if (cyc == t_g + T - 1) begin
                        t_ack = cyc + 2; t_err = 1'b1; t_data = 32'h0;
                    end
                end
                if (t_act && cyc == t_ack) begin
                    last_mem = t_mem;
                    t_act = 1'b0;
                end
                if (!t_act) begin
                    m_req = mem_ce_i && !e_mack;
                    i_req = if_ce_i && !e_iack;
                    if (m_req || i_req) begin
                        t_act   = 1'b1;
                        t_mem   = m_req && !(last_mem && i_req);
                        t_g     = cyc + 1;
                        t_addr  = t_mem ? mem_addr_i : if_addr_i;
                        t_we    = t_mem ? mem_we_i : 1'b0;
                        t_sel   = t_mem ? mem_sel_i : 4'hF;
                        t_wdata = t_mem ? mem_data_i : 32'h0;
                        t_err   = 1'b0;
                        if (t_addr >= 32'h8000_0000 && t_addr <= 32'h807F_FFFF) begin
                            t_kind = K_SRAM;
                            t_ack  = t_g + W + 1;
                            t_data = t_we ? 32'h0 : model_mem[t_addr[7:2]];
                            if (t_we)
                                for (int b = 0; b < 4; b++)
                                    if (t_sel[b]) model_mem[t_addr[7:2]][8*b +: 8] = t_wdata[8*b +: 8];
                        end else if (t_mem && (t_addr == 32'hBFD0_03F8 || t_addr == 32'hBFD0_03FC)) begin
                            t_kind = K_UART;
                            t_ack  = -1;
                        end else begin
                            t_kind = K_NONE;
                            t_ack  = t_g + 1;
                            t_err  = 1'b1;
                            t_data = 32'h0;
                        end
                    end
                end
            end
        end
    end

    // Results of the last applyStimulus call.
    int          r_lat, r_scyc, r_ucyc;
    logic [31:0] r_data;
    logic        r_err, r_ureg, r_stall_ok;
    logic [19:0] r_saddr;
    logic [3:0]  r_sbe;
    logic [7:0]  r_uwd;

    // Issue one request, optionally pulse uart_ready_i ready_at cycles after
    // the request cycle, and wait (bounded) for the owner's ack.
    task automatic applyStimulus(input bit to_mem, input bit we, input logic [31:0] addr,
                                 input logic [3:0] sel, input logic [31:0] wdata, input int ready_at);
        bit done;
        @(posedge clk); #1;
        if (to_mem) begin
            mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wdata;
        end else begin
            if_ce_i = 1'b1; if_addr_i = addr;
        end
        done = 1'b0; r_lat = -1; r_scyc = 0; r_ucyc = 0; r_stall_ok = 1'b1;
        r_data = 32'hX; r_err = 1'bX; r_saddr = 20'h0; r_sbe = 4'h0; r_uwd = 8'h0; r_ureg = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            uart_ready_i = (ready_at >= 0 && n == ready_at);
            @(negedge clk);
            if (sram_ce_o) begin r_scyc++; r_saddr = sram_addr_o; r_sbe = sram_be_o; end
            if (uart_ce_o) begin r_ucyc++; r_uwd = uart_wdata_o; r_ureg = uart_reg_o; end
            if (to_mem ? mem_ack_o : if_ack_o) begin
                done = 1'b1; r_lat = n;
                r_data = to_mem ? mem_data_o : if_data_o;
                r_err = bus_err_o;
            end else begin
                if (!stall_req_o) r_stall_ok = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (!done) checkOutput("ack_wait_expired", 32'h0, 32'h1);
        @(posedge clk); #1;
        mem_ce_i = 1'b0; if_ce_i = 1'b0; mem_we_i = 1'b0; uart_ready_i = 1'b0;
        mem_data_i = 32'h0; mem_sel_i = 4'h0;
    endtask

    logic [3:0] order;
    int         nacks;
    bit         got;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_ack", 32'(mem_ack_o), 32'h0);
        checkOutput("rst_sram_ce", 32'(sram_ce_o), 32'h0);
        checkOutput("rst_mem_data", mem_data_o, 32'h0);
        rst = 1'b0; preload = 1'b0;
        repeat (2) @(posedge clk);

        // Contention: both held, grants must alternate starting with MEM.
        #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000_0020; mem_sel_i = 4'hF;
        if_ce_i = 1'b1; if_addr_i = 32'h8000_0004;
        order = 4'h0; nacks = 0;
        for (int n = 0; n < 80 && nacks < 4; n++) begin
            @(negedge clk);
            if (mem_ack_o) begin order = {order[2:0], 1'b1}; nacks++; end
            if (if_ack_o)  begin order = {order[2:0], 1'b0}; nacks++; end
        end
        @(posedge clk); #1;
        mem_ce_i = 1'b0; if_ce_i = 1'b0;
        checkOutput("contention_acks", 32'(nacks), 32'd4);
        checkOutput("contention_order", 32'(order), 32'hA);
        repeat (8) @(posedge clk);

        // SRAM full-word write, then read back.
        applyStimulus(1'b1, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, -1);
        checkOutput("sw_latency", 32'(r_lat), 32'd4);
        checkOutput("sw_ce_cycles", 32'(r_scyc), 32'd2);
        checkOutput("sw_addr", 32'(r_saddr), 32'h0_0004);
        checkOutput("sw_be", 32'(r_sbe), 32'hF);
        checkOutput("sw_err", 32'(r_err), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0, -1);
        checkOutput("sr_data", r_data, 32'hDEAD_BEEF);
        checkOutput("sr_err", 32'(r_err), 32'h0);

        // Partial write on the low half, read merges with old upper half.
        applyStimulus(1'b1, 1'b1, 32'h8000_0010, 4'b0011, 32'h1122_3344, -1);
        applyStimulus(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0, -1);
        checkOutput("partial_data", r_data, 32'hDEAD_3344);

        // Top of SRAM window maps, one past it does not.
        applyStimulus(1'b1, 1'b1, 32'h807F_FFFC, 4'hF, 32'h0BAD_F00D, -1);
        checkOutput("top_addr", 32'(r_saddr), 32'h000F_FFFF);
        applyStimulus(1'b0, 1'b0, 32'h807F_FFFC, 4'hF, 32'h0, -1);
        checkOutput("top_if_data", r_data, 32'h0BAD_F00D);
        applyStimulus(1'b1, 1'b0, 32'h8080_0000, 4'hF, 32'h0, -1);
        checkOutput("past_top_err", 32'(r_err), 32'h1);
        checkOutput("past_top_lat", 32'(r_lat), 32'd2);

        // UART data write, ready three cycles after request.
        applyStimulus(1'b1, 1'b1, 32'hBFD0_03F8, 4'b0001, 32'h0000_0041, 3);
        checkOutput("uw_wdata", 32'(r_uwd), 32'h41);
        checkOutput("uw_reg", 32'(r_ureg), 32'h0);
        checkOutput("uw_cycles", 32'(r_ucyc), 32'd3);
        checkOutput("uw_latency", 32'(r_lat), 32'd5);
        checkOutput("uw_stall", 32'(r_stall_ok), 32'h1);
        checkOutput("uw_err", 32'(r_err), 32'h0);

        // Lane select from the lowest enabled byte.
        applyStimulus(1'b1, 1'b1, 32'hBFD0_03F8, 4'b1100, 32'h12AB_0000, 1);
        checkOutput("lane_wdata", 32'(r_uwd), 32'hAB);
        checkOutput("lane_latency", 32'(r_lat), 32'd3);

        // UART data read.
        applyStimulus(1'b1, 1'b0, 32'hBFD0_03F8, 4'b0001, 32'h0, 1);
        checkOutput("ur_data", r_data, 32'h0000_005A);

        // UART status read with ready stuck low times out.
        applyStimulus(1'b1, 1'b0, 32'hBFD0_03FC, 4'hF, 32'h0, -1);
        checkOutput("uto_err", 32'(r_err), 32'h1);
        checkOutput("uto_data", r_data, 32'h0);
        checkOutput("uto_reg", 32'(r_ureg), 32'h1);
        checkOutput("uto_cycles", 32'(r_ucyc), 32'd4);
        checkOutput("uto_latency", 32'(r_lat), 32'd6);

        // Unmapped IF fetch, and IF to a UART address.
        applyStimulus(1'b0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, -1);
        checkOutput("unm_latency", 32'(r_lat), 32'd2);
        checkOutput("unm_err", 32'(r_err), 32'h1);
        checkOutput("unm_sram", 32'(r_scyc), 32'd0);
        checkOutput("unm_uart", 32'(r_ucyc), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'hBFD0_03F8, 4'hF, 32'h0, 0);
        checkOutput("if_uart_err", 32'(r_err), 32'h1);
        checkOutput("if_uart_ce", 32'(r_ucyc), 32'd0);

        // Reset during an SRAM access; the held request restarts afterwards.
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000_0010; mem_sel_i = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_sram_ce", 32'(sram_ce_o), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_sram_ce", 32'(sram_ce_o), 32'h0);
        checkOutput("mid_rst_addr", 32'(sram_addr_o), 32'h0);
        checkOutput("mid_rst_stall", 32'(stall_req_o), 32'h0);
        checkOutput("mid_rst_data", mem_data_o, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        got = 1'b0; r_lat = -1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (mem_ack_o) begin got = 1'b1; r_lat = n; r_data = mem_data_o; end
        end
        checkOutput("post_rst_latency", 32'(r_lat), 32'd4);
        checkOutput("post_rst_data", r_data, 32'hDEAD_3344);
        @(posedge clk); #1;
        mem_ce_i = 1'b0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external SRAM port and the UART register port between instruction fetch (IF, read-only) and the MEM stage (read/write).
- Decodes the address, sequences multi-cycle SRAM and handshaked UART accesses, returns data with a one-cycle ack, and raises a pipeline stall until the pending access completes.
- Sits between the pipeline (IF / MEM stage) and the SRAM/UART pin-level controllers.

Parameters:
SRAM_WAIT, 2, SRAM access cycles after grant before data is sampled (1..15)
UART_TIMEOUT, 255, max cycles waiting for uart_ready_i before bus error (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
if_ce_i  in  1  IF read request, held until if_ack_o
if_addr_i  in  32  IF byte address
if_data_o  out  32  IF read data, valid with if_ack_o
if_ack_o  out  1  IF access complete (1-cycle pulse)
mem_ce_i  in  1  MEM request, held until mem_ack_o
mem_we_i  in  1  1 = write
mem_addr_i  in  32  MEM byte address
mem_sel_i  in  4  byte enables
mem_data_i  in  32  MEM write data
mem_data_o  out  32  MEM read data, valid with mem_ack_o
mem_ack_o  out  1  MEM access complete (1-cycle pulse)
bus_err_o  out  1  pulses with ack on unmapped address or UART timeout
stall_req_o  out  1  pipeline stall request
sram_ce_o  out  1  SRAM chip enable
sram_we_o  out  1  SRAM write enable
sram_addr_o  out  20  SRAM word address = addr[21:2]
sram_be_o  out  4  SRAM byte enables
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data
uart_ce_o  out  1  UART register access
uart_we_o  out  1  UART write
uart_reg_o  out  1  0 = data (0xBFD003F8), 1 = status (0xBFD003FC)
uart_wdata_o  out  8  UART write byte
uart_rdata_i  in  8  UART read byte
uart_ready_i  in  1  UART completes access this cycle

Behaviour:
- Address map: SRAM 0x80000000–0x807FFFFF; UART 0xBFD003F8 / 0xBFD003FC; everything else unmapped.
- Reset (async): FSM to IDLE, counters 0, last_grant = IF; every output 0. An in-flight access is dropped; the requester reissues it, since ce is still held.
- FSM states:
  - IDLE: if any request, grant and latch addr/we/sel/wdata/owner.
    - Priority: MEM wins, except when last_grant = MEM and IF is pending (alternation, so neither starves).
    - Decode: SRAM -> S_SRAM with cnt = SRAM_WAIT; UART -> S_UART with cnt = 0; unmapped -> S_DONE with err = 1.
  - S_SRAM: sram_ce_o = 1; sram_we_o = latched we; be = latched sel (IF: 4'b1111). Decrement cnt. At cnt == 1, sample sram_rdata_i into the data register and go to S_DONE.
  - S_UART: uart_ce_o = 1; uart_we_o / uart_reg_o from latch.
    - uart_wdata_o = byte lane of the lowest set sel bit (0001 -> [7:0], 0010 -> [15:8], …).
    - On uart_ready_i, capture {24'b0, uart_rdata_i} and go to S_DONE.
    - If cnt reaches UART_TIMEOUT, go to S_DONE with err = 1 and data 0.
    - IF requests to the UART decode as unmapped.
  - S_DONE: pulse the owner's ack for one cycle with its data bus = data register (0 on write/err); bus_err_o = err. Update last_grant; go to IDLE.
- Latency: SRAM access acks SRAM_WAIT+2 cycles after request seen in IDLE; UART acks 2 cycles after uart_ready_i sampled (min); unmapped acks 2 cycles after request.
- stall_req_o = (mem_ce_i & ~mem_ack_o) | (if_ce_i & ~if_ack_o), combinational.
- Data outputs hold last value between acks; non-owner ack stays 0.
- A request deasserted before ack: the access still completes, and the ack is ignored by the pipeline.
- Simultaneous new request during S_DONE: not granted until IDLE, so there is no same-cycle regrant.
- sram_*_o and uart_*_o outputs are 0 outside their states.

Test Plan:
- SRAM write then read, SRAM_WAIT=2: MEM we=1, addr 0x80000010, sel 1111, data 0xDEADBEEF -> sram_addr_o=0x00004, be=1111 for 2 cycles; mem_ack_o 4 cycles after request. Read back -> mem_data_o=0xDEADBEEF, bus_err_o=0.
- Contention: IF and MEM requests held continuously -> grants alternate MEM, IF, MEM, IF; no requester waits more than one foreign access.
- UART write: MEM we=1, addr 0xBFD003F8, sel 0001, data 0x41; uart_ready_i after 3 cycles -> uart_wdata_o=0x41, uart_reg_o=0; ack follows; stall_req_o high until ack.
- UART status timeout, UART_TIMEOUT=4, uart_ready_i stuck 0: read 0xBFD003FC -> ack with bus_err_o=1, mem_data_o=0.
- Unmapped address: IF fetch at 0x00001000 -> if_ack_o with bus_err_o=1 two cycles later; no sram_ce_o or uart_ce_o asserted.
- Reset mid-access: assert rst during S_SRAM -> all outputs 0 immediately; after release, the held request restarts from IDLE and completes correctly.
